// File: rtl/pipe_pkg.sv
// Shared constants and PC arithmetic for the MIPS inter-stage pipeline registers.
// Pure declarations; no logic, no latency, no flow control.
// Optional perf counters elsewhere are enabled with STAGE_PERF_EN.
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;

  // Plain 32-bit modulo add; wraps past 0xFFFFFFFF without any flag.
  function automatic logic [31:0] pc_plus(input logic [31:0] pc, input logic [31:0] n);
    return pc + n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that sticks at all-ones; built only when STAGE_PERF_EN is defined.
// Latency: count updates on the edge after inc is seen.
// Backpressure: none; the count is always readable.
`ifdef STAGE_PERF_EN
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q = '0;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (IR, PC, N_DATA channels, valid); STAGE_PERF_EN adds stall/flush counters.
// Latency: 1 cycle input to output when en=1; pc4_o/pc8_o derive only from the PC register.
// Backpressure: en=0 holds all contents; flush (beats stall) and reset load a bubble.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          N_DATA    = 2,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int          CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     valid_i,
  input  logic [31:0]              ir_i,
  input  logic [31:0]              pc_i,
  input  logic [N_DATA*DATA_W-1:0] data_i,
  output logic                     valid_o,
  output logic [31:0]              ir_o,
  output logic [31:0]              pc_o,
  output logic [31:0]              pc4_o,
  output logic [31:0]              pc8_o,
  output logic [N_DATA*DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         flush_cnt_o
);

  if ((N_DATA < 1) || (N_DATA > 8)) begin : g_bad_n_data
    $error("pipe_stage_reg: N_DATA must be in 1..8");
  end

  // Power-up values match the bubble so simulation starts in the reset state.
  logic                     valid_q = 1'b0;
  logic [31:0]              ir_q    = NOP_INSTR;
  logic [31:0]              pc_q    = RESET_PC;
  logic [N_DATA*DATA_W-1:0] data_q  = '0;

  logic                     valid_d;
  logic [31:0]              ir_d;
  logic [31:0]              pc_d;
  logic [N_DATA*DATA_W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ir_d    = NOP_INSTR;
      pc_d    = RESET_PC;
      data_d  = '0;
    end else if (en) begin
      valid_d = valid_i;
      pc_d    = pc_i;
      // An invalid slot never forwards a stale instruction or operands.
      ir_d    = valid_i ? ir_i : NOP_INSTR;
      data_d  = valid_i ? data_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ir_q    <= NOP_INSTR;
      pc_q    <= RESET_PC;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ir_o    = ir_q;
  assign pc_o    = pc_q;
  assign data_o  = data_q;
  assign pc4_o   = pc_plus(pc_q, PC_STEP);
  assign pc8_o   = pc_plus(pc_q, PC_STEP + PC_STEP);

`ifdef STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  // Only a real instruction sitting in a stalled slot counts as a stall cycle.
  assign stall_inc = ~en & ~flush & valid_q;
  assign flush_inc = flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
